// File: rtl/mem_io_responder_if.sv
// Request/response bus between the LC-3 datapath (MAR/MDR side) and the memory/IO responder.
interface mem_io_responder_if;
   logic        MEM_EN;
   logic        R_W;
   logic [15:0] MAR;
   logic [15:0] MDR;
   logic [15:0] MEM_OUT;
   logic        R;

   modport master (output MEM_EN, R_W, MAR, MDR, input MEM_OUT, R);
   modport slave  (input MEM_EN, R_W, MAR, MDR, output MEM_OUT, R);
endinterface

// File: rtl/mem_io_responder.sv
// LC-3 memory and keyboard/display responder with programmable wait states.
// Optional keyboard interrupt enable: define LC3_KB_INT_EN.
//
// state | meaning
// IDLE  | waiting for MEM_EN, request latched on accept
// BUSY  | counting wait states, access commits when cnt reaches 0
// DONE  | R pulsed for this cycle, read data valid on MEM_OUT
module mem_io_responder #(
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int WAIT_CYCLES    = 2
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   mem_io_responder_if.slave       bus,
   input  logic [7:0]              KB_DATA,
   input  logic                    KB_STROBE,
   input  logic                    DISP_READY,
   output logic [7:0]              DDR_OUT,
   output logic                    DDR_VALID,
   output logic                    o_KB_INT
);

   localparam int          MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
   localparam logic [15:0] A_KBSR    = 16'hFE00;
   localparam logic [15:0] A_KBDR    = 16'hFE02;
   localparam logic [15:0] A_DSR     = 16'hFE04;
   localparam logic [15:0] A_DDR     = 16'hFE06;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] mar_q, mar_d;
   logic [15:0] mdr_q, mdr_d;
   logic        rw_q, rw_d;
   logic [15:0] mem_out_q, mem_out_d;
   logic [7:0]  ddr_out_q, ddr_out_d;
   logic        ddr_valid_q, ddr_valid_d;
   logic        kb_rdy_q, kb_rdy_d;
   logic        kb_ie_q, kb_ie_d;
   logic [7:0]  kbdr_q, kbdr_d;
   logic        ds_rdy_q, ds_rdy_d;
   logic        kb_int_q, kb_int_d;

   logic [15:0] mem_array [MEM_DEPTH];
   logic        mem_we;
   logic        commit;
   logic        is_mem;
   logic [15:0] rd_data;

   assign commit = (state_q == BUSY) && (cnt_q == 4'd0);
   assign is_mem = (mar_q < A_KBSR);

   always_comb begin
      rd_data = 16'h0000;
      if (is_mem) begin
         rd_data = mem_array[mar_q[MEM_DEPTH_LOG2-1:0]];
      end else begin
         case (mar_q)
            A_KBSR:  rd_data = {kb_rdy_q, kb_ie_q, 14'b0};
            A_KBDR:  rd_data = {8'b0, kbdr_q};
            A_DSR:   rd_data = {ds_rdy_q, 15'b0};
            A_DDR:   rd_data = {8'b0, ddr_out_q};
            default: rd_data = 16'h0000;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mar_d       = mar_q;
      mdr_d       = mdr_q;
      rw_d        = rw_q;
      mem_out_d   = mem_out_q;
      ddr_out_d   = ddr_out_q;
      ddr_valid_d = 1'b0;
      kb_rdy_d    = kb_rdy_q;
      kb_ie_d     = kb_ie_q;
      kbdr_d      = kbdr_q;
      ds_rdy_d    = ds_rdy_q;
      mem_we      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.MEM_EN) begin
               mar_d   = bus.MAR;
               mdr_d   = bus.MDR;
               rw_d    = bus.R_W;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (!ds_rdy_q && DISP_READY) ds_rdy_d = 1'b1;

      if (commit) begin
         if (rw_q) begin
            if (is_mem) begin
               mem_we = 1'b1;
            end else if (mar_q == A_DDR) begin
               ddr_out_d   = mdr_q[7:0];
               ddr_valid_d = 1'b1;
               ds_rdy_d    = 1'b0;
            end
`ifdef LC3_KB_INT_EN
            else if (mar_q == A_KBSR) begin
               kb_ie_d = mdr_q[14];
            end
`endif
         end else begin
            mem_out_d = rd_data;
            if (mar_q == A_KBDR) kb_rdy_d = 1'b0;
         end
      end

      // A strobe on the KBDR read edge wins; the read above already captured the old data.
      if (KB_STROBE) begin
         kbdr_d   = KB_DATA;
         kb_rdy_d = 1'b1;
      end

`ifdef LC3_KB_INT_EN
      kb_int_d = kb_rdy_d & kb_ie_d;
`else
      kb_ie_d  = 1'b0;
      kb_int_d = 1'b0;
`endif
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         mar_q       <= 16'h0000;
         mdr_q       <= 16'h0000;
         rw_q        <= 1'b0;
         mem_out_q   <= 16'h0000;
         ddr_out_q   <= 8'h00;
         ddr_valid_q <= 1'b0;
         kb_rdy_q    <= 1'b0;
         kb_ie_q     <= 1'b0;
         kbdr_q      <= 8'h00;
         ds_rdy_q    <= 1'b1;
         kb_int_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mar_q       <= mar_d;
         mdr_q       <= mdr_d;
         rw_q        <= rw_d;
         mem_out_q   <= mem_out_d;
         ddr_out_q   <= ddr_out_d;
         ddr_valid_q <= ddr_valid_d;
         kb_rdy_q    <= kb_rdy_d;
         kb_ie_q     <= kb_ie_d;
         kbdr_q      <= kbdr_d;
         ds_rdy_q    <= ds_rdy_d;
         kb_int_q    <= kb_int_d;
      end
   end

   // Memory contents survive reset; only the write itself is suppressed.
   always_ff @(posedge i_Clk) begin
      if (mem_we && !i_Rst) mem_array[mar_q[MEM_DEPTH_LOG2-1:0]] <= mdr_q;
   end

   assign bus.R       = (state_q == DONE);
   assign bus.MEM_OUT = mem_out_q;
   assign DDR_OUT     = ddr_out_q;
   assign DDR_VALID   = ddr_valid_q;
   assign o_KB_INT    = kb_int_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized scoreboard bench for mem_io_responder against a register-level reference model.
module tb_mem_io_responder;
   localparam int W  = 2;
   localparam int DL = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] kb_data;
   logic       kb_strobe;
   logic       disp_ready;
   logic [7:0] ddr_out;
   logic       ddr_valid;
   logic       kb_int;

   mem_io_responder_if bus ();

   mem_io_responder #(.MEM_DEPTH_LOG2(DL), .WAIT_CYCLES(W)) dut (
      .i_Clk(clk), .i_Rst(rst), .bus(bus),
      .KB_DATA(kb_data), .KB_STROBE(kb_strobe), .DISP_READY(disp_ready),
      .DDR_OUT(ddr_out), .DDR_VALID(ddr_valid), .o_KB_INT(kb_int)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          rd;
      logic [15:0] addr;
      logic [15:0] data;
      bit          ddr;
      logic [7:0]  ddr_b;
      int          cyc;
   } exp_t;
   exp_t sbq[$];

   // reference model state
   logic [15:0] mem_m [1024];
   bit          m_kb_rdy, m_kb_ie, m_ds_rdy;
   logic [7:0]  m_kbdr, m_ddr;
   bit          disp_lvl;
`ifdef LC3_KB_INT_EN
   localparam bit INT_EN = 1'b1;
`else
   localparam bit INT_EN = 1'b0;
`endif

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_kb_rdy = 0; m_kb_ie = 0; m_ds_rdy = 1; m_kbdr = 8'h00; m_ddr = 8'h00;
   endtask

   // monitor: pops one expectation per R pulse
   bit r_prev = 0;
   always @(negedge clk) begin
      if (bus.R && r_prev) begin
         total++; bad++;
         $display("FAIL r_width: R high for two consecutive cycles");
      end
      if (bus.R) begin
         if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL r_unexpected: R=1 with no outstanding request (cyc=%0d)", cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("r_latency", 16'(cyc), 16'(e.cyc));
            if (e.rd) chk($sformatf("rd_data@%h", e.addr), bus.MEM_OUT, e.data);
            chk("ddr_valid", {15'b0, ddr_valid}, {15'b0, e.ddr});
            if (e.ddr) chk("ddr_out", {8'b0, ddr_out}, {8'b0, e.ddr_b});
         end
      end else if (ddr_valid) begin
         total++; bad++;
         $display("FAIL ddr_valid_stray: DDR_VALID=1 outside a DDR write completion");
      end
      r_prev = bus.R;
   end

   task automatic xact(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                       input bit strobe_at_commit = 0, input logic [7:0] sdata = 8'h00);
      exp_t e;
      e.rd = !wr; e.addr = addr; e.data = 16'h0000; e.ddr = 0; e.ddr_b = 8'h00;
      if (wr) begin
         if (addr < 16'hFE00) mem_m[addr[9:0]] = data;
         else if (addr == 16'hFE00 && INT_EN) m_kb_ie = data[14];
         else if (addr == 16'hFE06) begin
            m_ddr = data[7:0]; e.ddr = 1; e.ddr_b = data[7:0];
            m_ds_rdy = disp_lvl;
         end
      end else begin
         if (addr < 16'hFE00) e.data = mem_m[addr[9:0]];
         else if (addr == 16'hFE00) e.data = {m_kb_rdy, m_kb_ie, 14'b0};
         else if (addr == 16'hFE02) begin e.data = {8'b0, m_kbdr}; m_kb_rdy = 0; end
         else if (addr == 16'hFE04) e.data = {m_ds_rdy, 15'b0};
         else if (addr == 16'hFE06) e.data = {8'b0, m_ddr};
      end
      if (strobe_at_commit) begin m_kbdr = sdata; m_kb_rdy = 1; end

      @(negedge clk);
      bus.MEM_EN = 1; bus.R_W = wr; bus.MAR = addr; bus.MDR = data;
      @(posedge clk); #1;
      e.cyc = cyc + W + 1;
      sbq.push_back(e);
      bus.MEM_EN = 0; bus.R_W = $urandom_range(0, 1);
      bus.MAR = 16'($urandom); bus.MDR = 16'($urandom);
      if (strobe_at_commit) begin
         repeat (W) @(posedge clk);
         @(negedge clk); kb_strobe = 1; kb_data = sdata;
         @(posedge clk); #1; kb_strobe = 0;
      end
      begin
         bit seen = 0;
         for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.R) seen = 1;
         end
         if (!seen) begin
            total++; bad++;
            $display("FAIL r_timeout: no R for access to %h", addr);
            sbq.delete();
         end
      end
      chk("kb_int", {15'b0, kb_int}, {15'b0, m_kb_rdy & m_kb_ie & INT_EN});
   endtask

   task automatic strobe(input logic [7:0] d);
      @(negedge clk); kb_strobe = 1; kb_data = d;
      @(posedge clk); #1; kb_strobe = 0;
      m_kbdr = d; m_kb_rdy = 1;
   endtask

   task automatic set_disp(input bit v);
      @(negedge clk); disp_ready = v;
      @(posedge clk); #1;
      disp_lvl = v;
      if (v) m_ds_rdy = 1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [9:0] pool [8];

   initial begin
      rst = 1; kb_data = 0; kb_strobe = 0; disp_ready = 0; disp_lvl = 0;
      bus.MEM_EN = 0; bus.R_W = 0; bus.MAR = 0; bus.MDR = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_mem_out", bus.MEM_OUT, 16'h0000);
      chk("rst_r", {15'b0, bus.R}, 16'h0000);
      chk("rst_ddr_out", {8'b0, ddr_out}, 16'h0000);
      chk("rst_ddr_valid", {15'b0, ddr_valid}, 16'h0000);
      chk("rst_kb_int", {15'b0, kb_int}, 16'h0000);

      // directed: latency, aliasing
      xact(1, 16'h3000, 16'h1234);
      xact(0, 16'h3000, 16'h0000);
      chk("dir_rd_3000", bus.MEM_OUT, 16'h1234);
      xact(1, 16'h0005, 16'hABCD);
      xact(0, 16'h0405, 16'h0000);
      chk("dir_alias", bus.MEM_OUT, 16'hABCD);

      // keyboard
      strobe(8'h41);
      xact(0, 16'hFE00, 0); chk("dir_kbsr_set", bus.MEM_OUT, 16'h8000);
      xact(0, 16'hFE02, 0); chk("dir_kbdr", bus.MEM_OUT, 16'h0041);
      xact(0, 16'hFE00, 0); chk("dir_kbsr_clr", bus.MEM_OUT, 16'h0000);

      // display
      xact(0, 16'hFE04, 0); chk("dir_dsr_idle", bus.MEM_OUT, 16'h8000);
      xact(1, 16'hFE06, 16'h0048);
      chk("dir_ddr_out", {8'b0, ddr_out}, 16'h0048);
      xact(0, 16'hFE04, 0); chk("dir_dsr_busy", bus.MEM_OUT, 16'h0000);
      set_disp(1);
      xact(0, 16'hFE04, 0); chk("dir_dsr_ready", bus.MEM_OUT, 16'h8000);
      set_disp(0);

      // strobe landing on the KBDR read commit edge
      strobe(8'h11);
      xact(0, 16'hFE02, 0, 1, 8'h22); chk("dir_kbdr_race_old", bus.MEM_OUT, 16'h0011);
      xact(0, 16'hFE00, 0); chk("dir_kbsr_race", bus.MEM_OUT[15], 16'(1'b1));
      xact(0, 16'hFE02, 0); chk("dir_kbdr_race_new", bus.MEM_OUT, 16'h0022);

      // reset abort mid-BUSY
      xact(1, 16'h3001, 16'h1111);
      @(negedge clk);
      bus.MEM_EN = 1; bus.R_W = 1; bus.MAR = 16'h3001; bus.MDR = 16'h2222;
      @(posedge clk); #1 bus.MEM_EN = 0;
      @(negedge clk); rst = 1;
      @(posedge clk); #1 rst = 0;
      model_reset();
      repeat (10) @(negedge clk);
      chk("abort_r_low", {15'b0, bus.R}, 16'h0000);
      xact(0, 16'h3001, 0); chk("abort_mem", bus.MEM_OUT, 16'h1111);

      // interrupt
      xact(1, 16'hFE00, 16'h4000);
      strobe(8'h55);
      chk("int_after_strobe", {15'b0, kb_int}, {15'b0, INT_EN});
      xact(0, 16'hFE00, 0);
      chk("int_kbsr", bus.MEM_OUT, INT_EN ? 16'hC000 : 16'h8000);
      xact(0, 16'hFE02, 0);
      chk("int_cleared", {15'b0, kb_int}, 16'h0000);

      // randomized phase
      for (int i = 0; i < 8; i++) begin
         pool[i] = 10'($urandom);
         xact(1, {6'($urandom_range(0, 62)), pool[i]}, 16'($urandom));
      end
      for (int n = 0; n < 150; n++) begin
         int k;
         k = $urandom_range(0, 11);
         if (k == 0) strobe(8'($urandom));
         else if (k == 1) set_disp(1'($urandom_range(0, 1)));
         else if (k == 2) begin
            if (!m_kb_rdy) strobe(8'($urandom));
            xact(0, 16'hFE02, 0, 1, 8'($urandom));
         end else begin
            int s;
            logic [15:0] a;
            s = $urandom_range(0, 9);
            if (s <= 5) a = {6'($urandom_range(0, 62)), pool[$urandom_range(0, 7)]};
            else if (s <= 8) a = 16'hFE00 + 16'(2 * $urandom_range(0, 3));
            else begin
               logic [15:0] odd [4];
               odd = '{16'hFE01, 16'hFE08, 16'hFFFE, 16'hFE03};
               a = odd[$urandom_range(0, 3)];
            end
            xact(1'($urandom_range(0, 1)), a, 16'($urandom));
         end
      end

      repeat (5) @(negedge clk);
      chk("sb_empty", 16'(sbq.size()), 16'h0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
